// File: rtl/lut_rom_lookup_arb_pkg.sv
// Shared constants and helpers for the LUT ROM lookup arbiter.
// Optional grant statistics are enabled with LUT_ROM_ARB_STATS_EN.
package lut_rom_pkg;

    localparam int LUT_ROM_ADDR_W = 5;
    localparam int LUT_ROM_DEPTH  = 32;
    localparam int LUT_ROM_LAT    = 1;
    localparam int ARB_LAT        = 2;
    localparam int STAT_CNT_W     = 16;

    // Round-robin successor of idx within 0..n-1.
    function automatic int rr_next(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [STAT_CNT_W-1:0] sat_inc(input logic [STAT_CNT_W-1:0] v);
        if (v == {STAT_CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(STAT_CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/lut_rom_lookup_arb_if.sv
// Requester/ROM bus bundle for lut_rom_lookup_arb; grant_cnt exists only
// when LUT_ROM_ARB_STATS_EN is defined.
interface lut_rom_lookup_arb_if #(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 32
);
    import lut_rom_pkg::*;

    logic                              arb_en;
    logic [NUM_REQ-1:0]                req_valid;
    logic [LUT_ROM_ADDR_W*NUM_REQ-1:0] req_addr;
    logic [NUM_REQ-1:0]                req_ready;
    logic [LUT_ROM_ADDR_W-1:0]         rom_addr;
    logic [BUS_WIDTH-1:0]              rom_dout;
    logic [NUM_REQ-1:0]                resp_valid;
    logic [BUS_WIDTH-1:0]              resp_data;
`ifdef LUT_ROM_ARB_STATS_EN
    logic [STAT_CNT_W*NUM_REQ-1:0]     grant_cnt;
`endif

    modport slave (
        input  arb_en, req_valid, req_addr, rom_dout,
`ifdef LUT_ROM_ARB_STATS_EN
        output grant_cnt,
`endif
        output req_ready, rom_addr, resp_valid, resp_data
    );

    modport master (
        output arb_en, req_valid, req_addr, rom_dout,
`ifdef LUT_ROM_ARB_STATS_EN
        input  grant_cnt,
`endif
        input  req_ready, rom_addr, resp_valid, resp_data
    );

endinterface

// File: rtl/lut_rom_lookup_arb_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or above ptr_i, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o
);

    int   idx_s;
    logic found_s;

    // Rotating priority search starting at the pointer.
    always_comb begin
        gnt_o   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < N; k++) begin
            idx_s = int'(ptr_i) + k;
            if (idx_s >= N) begin
                idx_s = idx_s - N;
            end else begin
                idx_s = idx_s;
            end
            if (en_i && !found_s && req_i[idx_s]) begin
                gnt_o[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/lut_rom_lookup_arb.sv
// Round-robin sharing of one registered-read lookup ROM among NUM_REQ requesters.
// Define LUT_ROM_ARB_STATS_EN to add saturating per-requester grant counters.
module lut_rom_lookup_arb
    import lut_rom_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 32
) (
    input logic                 clk,
    input logic                 rst,
    lut_rom_lookup_arb_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        gnt_s;
    logic                      hs_s;
    logic [PTR_W-1:0]          win_idx_s;
    logic [LUT_ROM_ADDR_W-1:0] win_addr_s;
    logic [BUS_WIDTH-1:0]      resp_data_s;

    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [LUT_ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [NUM_REQ-1:0]        tag_a_q, tag_a_d, tag_b_q, tag_b_d;
    logic                      vld_a_q, vld_a_d, vld_b_q, vld_b_d;

    // Grants are gated by reset so nothing is accepted while rst is low.
    rr_arbiter #(.N(NUM_REQ), .PW(PTR_W)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (ptr_q),
        .en_i  (bus.arb_en & rst),
        .gnt_o (gnt_s)
    );

    assign hs_s = |gnt_s;

    // Encode the one-hot grant to an index and pick that requester's address.
    always_comb begin
        win_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                win_idx_s = PTR_W'(i);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
        win_addr_s = bus.req_addr[LUT_ROM_ADDR_W*int'(win_idx_s) +: LUT_ROM_ADDR_W];
    end

    // Next state: rom_addr holds when idle to keep the ROM address quiet.
    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        tag_a_d    = '0;
        vld_a_d    = 1'b0;
        if (hs_s) begin
            ptr_d      = PTR_W'(rr_next(int'(win_idx_s), NUM_REQ));
            rom_addr_d = win_addr_s;
            tag_a_d    = gnt_s;
            vld_a_d    = 1'b1;
        end else begin
            ptr_d = ptr_q;
        end
        tag_b_d = tag_a_q;
        vld_b_d = vld_a_q;
    end

    // Pointer, ROM address and tag pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            tag_a_q    <= '0;
            tag_b_q    <= '0;
            vld_a_q    <= 1'b0;
            vld_b_q    <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            tag_a_q    <= tag_a_d;
            tag_b_q    <= tag_b_d;
            vld_a_q    <= vld_a_d;
            vld_b_q    <= vld_b_d;
        end
    end

    assign resp_data_s    = bus.rom_dout;
    assign bus.req_ready  = gnt_s;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.resp_valid = vld_b_q ? tag_b_q : '0;
    assign bus.resp_data  = resp_data_s;

`ifdef LUT_ROM_ARB_STATS_EN
    logic [STAT_CNT_W-1:0] cnt_q [NUM_REQ];

    // Saturating grant counters, one per requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_s[i]) begin
                    cnt_q[i] <= sat_inc(cnt_q[i]);
                end else begin
                    cnt_q[i] <= cnt_q[i];
                end
            end
        end
    end

    // Flatten counters onto the grant_cnt bus.
    always_comb begin
        bus.grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.grant_cnt[STAT_CNT_W*i +: STAT_CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_lut_rom_lookup_arb.sv
// Randomised and directed bench for lut_rom_lookup_arb against a queue-based model.
// Exercises grant counters when LUT_ROM_ARB_STATS_EN is defined.
module tb_lut_rom_lookup_arb;
    import lut_rom_pkg::*;

    localparam int N  = 4;
    localparam int BW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lut_rom_lookup_arb_if #(.NUM_REQ(N), .BUS_WIDTH(BW)) bus ();
    lut_rom_lookup_arb #(.NUM_REQ(N), .BUS_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom_word(input logic [4:0] ad);
        return 32'h9E3779B9 * {27'd0, ad} + 32'h13572468;
    endfunction

    // External ROM: registered read, dout not reset.
    always @(posedge clk) bus.rom_dout <= rom_word(bus.rom_addr);

    typedef struct {
        int         due;
        int         idx;
        logic [4:0] addr;
    } pend_t;

    pend_t      m_q[$];
    int         m_ptr = 0;
    logic [4:0] m_addr = 5'd0;
    int         cyc = 0;
    int         m_cnt[N];
    int         n_checks = 0;
    int         n_pass = 0;
    int         last_win;

    logic [3:0]  obs_ready, obs_resp, exp_ready, exp_resp;
    logic [31:0] obs_data, exp_data;
    logic [4:0]  obs_addr, exp_addr;

    task automatic model_reset();
        m_q.delete();
        m_ptr  = 0;
        m_addr = 5'd0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // One clock: drive at negedge, sample DUT and model expectations, then advance.
    task automatic cycle(input logic [3:0] v, input logic [19:0] a, input logic en);
        int w;
        w = -1;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.arb_en    = en;
        #1;
        if (en && rst) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        exp_resp  = 4'b0000;
        exp_data  = 32'd0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            exp_resp = 4'b0001 << m_q[0].idx;
            exp_data = rom_word(m_q[0].addr);
            void'(m_q.pop_front());
        end
        exp_addr  = m_addr;
        obs_ready = bus.req_ready;
        obs_resp  = bus.resp_valid;
        obs_data  = bus.resp_data;
        obs_addr  = bus.rom_addr;
        last_win  = w;
        @(posedge clk);
        if (w >= 0) begin
            m_q.push_back('{cyc + 2, w, a[5*w +: 5]});
            m_ptr  = (w + 1) % N;
            m_addr = a[5*w +: 5];
            if (m_cnt[w] < 65535) m_cnt[w]++;
        end
        cyc++;
    endtask

    task automatic test_reset();
        bus.req_valid = 4'b1111;
        bus.req_addr  = 20'hFFFFF;
        bus.arb_en    = 1'b1;
        rst           = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", bus.req_ready);
            else n_pass++;
            n_checks++;
            if (bus.resp_valid !== 4'b0000 || bus.rom_addr !== 5'd0)
                $display("FAIL reset_state resp=%b addr=%0d want 0/0", bus.resp_valid, bus.rom_addr);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        // First cycle out of reset must already grant.
        cycle(4'b0100, {5'd0, 5'd9, 5'd0, 5'd0}, 1'b1);
        n_checks++;
        if (obs_ready !== 4'b0100) $display("FAIL first_grant got %b want 0100", obs_ready);
        else n_pass++;
        cycle(4'b0000, 20'd0, 1'b1);
        cycle(4'b0000, 20'd0, 1'b1);
        n_checks++;
        if (obs_resp !== 4'b0100 || obs_data !== rom_word(5'd9))
            $display("FAIL first_resp got %b/%h want 0100/%h", obs_resp, obs_data, rom_word(5'd9));
        else n_pass++;
    endtask

    task automatic test_single();
        cycle(4'b0010, {5'd0, 5'd0, 5'd7, 5'd0}, 1'b1);
        n_checks++;
        if (obs_ready !== 4'b0010) $display("FAIL single_ready got %b want 0010", obs_ready);
        else n_pass++;
        cycle(4'b0000, 20'd0, 1'b1);
        n_checks++;
        if (obs_addr !== 5'd7 || obs_resp !== 4'b0000)
            $display("FAIL single_addr got %0d/%b want 7/0000", obs_addr, obs_resp);
        else n_pass++;
        cycle(4'b0000, 20'd0, 1'b1);
        n_checks++;
        if (obs_resp !== 4'b0010 || obs_data !== rom_word(5'd7))
            $display("FAIL single_resp got %b/%h want 0010/%h", obs_resp, obs_data, rom_word(5'd7));
        else n_pass++;
    endtask

    task automatic test_all_req();
        int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        // Bring the pointer back to 0 by granting requester 3.
        cycle(4'b1000, 20'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle((i < 8) ? 4'b1111 : 4'b0000, {5'd3 + 5'(i), 5'd2 + 5'(i), 5'd1 + 5'(i), 5'(i)}, 1'b1);
            n_checks++;
            if (i < 8 && obs_ready !== (4'b0001 << order[i]))
                $display("FAIL all_req_order cycle %0d got %b want %b", i, obs_ready, 4'b0001 << order[i]);
            else n_pass++;
            n_checks++;
            if (obs_resp !== exp_resp || (exp_resp != 4'b0000 && obs_data !== exp_data))
                $display("FAIL all_req_resp cycle %0d got %b/%h want %b/%h", i, obs_resp, obs_data, exp_resp, exp_data);
            else n_pass++;
        end
    endtask

    task automatic test_wrap_skip();
        int order[3] = '{0, 2, 0};
        cycle(4'b0100, 20'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle((i < 3) ? 4'b0101 : 4'b0000, {5'd0, 5'd20 + 5'(i), 5'd0, 5'd10 + 5'(i)}, 1'b1);
            n_checks++;
            if (i < 3 && obs_ready !== (4'b0001 << order[i]))
                $display("FAIL wrap_order step %0d got %b want %b", i, obs_ready, 4'b0001 << order[i]);
            else n_pass++;
            n_checks++;
            if (obs_resp !== exp_resp || obs_addr !== exp_addr || (exp_resp != 4'b0000 && obs_data !== exp_data))
                $display("FAIL wrap_resp step %0d got %b/%0d want %b/%0d", i, obs_resp, obs_addr, exp_resp, exp_addr);
            else n_pass++;
        end
    endtask

    task automatic test_arb_en();
        cycle(4'b0001, {15'd0, 5'd17}, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, 1'b0);
            n_checks++;
            if (obs_ready !== 4'b0000) $display("FAIL arb_en_ready step %0d got %b want 0000", i, obs_ready);
            else n_pass++;
            n_checks++;
            if (obs_resp !== ((i == 1) ? 4'b0001 : 4'b0000) || (i == 1 && obs_data !== rom_word(5'd17)))
                $display("FAIL arb_en_drain step %0d got %b/%h", i, obs_resp, obs_data);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        cycle(4'b0100, {5'd0, 5'd25, 10'd0}, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.resp_valid !== 4'b0000 || bus.rom_addr !== 5'd0 || bus.req_ready !== 4'b0000)
            $display("FAIL reset_mid got resp=%b addr=%0d ready=%b want 0/0/0",
                     bus.resp_valid, bus.rom_addr, bus.req_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        cyc++;
        for (int i = 0; i < 4; i++) begin
            cycle((i == 0) ? 4'b1111 : 4'b0000, {5'd4, 5'd3, 5'd2, 5'd1}, 1'b1);
            n_checks++;
            if (i == 0 && obs_ready !== 4'b0001) $display("FAIL reset_mid_ptr got %b want 0001", obs_ready);
            else n_pass++;
            n_checks++;
            if (obs_resp !== exp_resp || (exp_resp != 4'b0000 && obs_data !== exp_data))
                $display("FAIL reset_mid_lost step %0d got %b want %b", i, obs_resp, exp_resp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(4'($urandom), 20'($urandom), ($urandom_range(0, 9) != 0));
            n_checks++;
            if (obs_ready !== exp_ready) $display("FAIL rand_ready %0d got %b want %b", i, obs_ready, exp_ready);
            else n_pass++;
            n_checks++;
            if (obs_addr !== exp_addr) $display("FAIL rand_addr %0d got %0d want %0d", i, obs_addr, exp_addr);
            else n_pass++;
            n_checks++;
            if (obs_resp !== exp_resp || (exp_resp != 4'b0000 && obs_data !== exp_data))
                $display("FAIL rand_resp %0d got %b/%h want %b/%h", i, obs_resp, obs_data, exp_resp, exp_data);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0000, 20'd0, 1'b1);
            n_checks++;
            if (obs_resp !== exp_resp) $display("FAIL rand_drain %0d got %b want %b", i, obs_resp, exp_resp);
            else n_pass++;
        end
    endtask

`ifdef LUT_ROM_ARB_STATS_EN
    task automatic test_stats();
        for (int i = 0; i < 70000; i++) cycle(4'b0010, 20'd0, 1'b1);
        cycle(4'b0000, 20'd0, 1'b1);
        n_checks++;
        if (bus.grant_cnt[31:16] !== 16'hFFFF) $display("FAIL stats_sat got %h want FFFF", bus.grant_cnt[31:16]);
        else n_pass++;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (bus.grant_cnt[16*i +: 16] !== 16'(m_cnt[i]))
                $display("FAIL stats_cnt%0d got %h want %h", i, bus.grant_cnt[16*i +: 16], 16'(m_cnt[i]));
            else n_pass++;
        end
    endtask
`endif

    initial begin
        bus.req_valid = 4'b0000;
        bus.req_addr  = 20'd0;
        bus.arb_en    = 1'b0;
        test_reset();
        test_single();
        test_all_req();
        test_wrap_skip();
        test_arb_en();
        test_reset_mid();
        test_random();
`ifdef LUT_ROM_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
